// File: rtl/mac_sched_pkg.sv
// Shared types and MAC constants for the matrix-vector MAC sequencer.
package mac_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SETTLE,
      ISSUE,
      DRAIN,
      OUTPUT
   } sched_state_t;

   // Cycles from MAC valid_in to MAC valid_out.
   localparam int MAC_VALID_LAT = 5;

   localparam int MAC_F_W = 28;
   localparam logic signed [MAC_F_W-1:0] MAC_SAT_MAX = {1'b0, {(MAC_F_W-1){1'b1}}};
   localparam logic signed [MAC_F_W-1:0] MAC_SAT_MIN = {1'b1, {(MAC_F_W-1){1'b0}}};

endpackage

// File: rtl/mac_sched_addr_gen.sv
// Row/column counters for the W and x memories, with end-of-row and last-row flags.
module mac_sched_addr_gen #(
   parameter int M = 4,
   parameter int N = 4,
   localparam int WA_W = (M * N > 1) ? $clog2(M * N) : 1,
   localparam int XA_W = (N > 1) ? $clog2(N) : 1,
   localparam int RW_W = (M > 1) ? $clog2(M) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_row_clr,
   input  logic            i_row_inc,
   input  logic            i_col_clr,
   input  logic            i_col_inc,
   output logic [WA_W-1:0] o_w_addr,
   output logic [XA_W-1:0] o_x_addr,
   output logic [RW_W-1:0] o_row,
   output logic            o_last_col,
   output logic            o_last_row
);

   localparam logic [WA_W-1:0] N_L = WA_W'(N);

   logic [RW_W-1:0] r_row;
   logic [XA_W-1:0] r_col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else begin
         if (i_row_clr)      r_row <= '0;
         else if (i_row_inc) r_row <= r_row + 1'b1;
         if (i_col_clr)      r_col <= '0;
         else if (i_col_inc) r_col <= r_col + 1'b1;
      end
   end

   assign o_w_addr   = WA_W'(r_row) * N_L + WA_W'(r_col);
   assign o_x_addr   = r_col;
   assign o_row      = r_row;
   assign o_last_col = (r_col == XA_W'(N - 1));
   assign o_last_row = (r_row == RW_W'(M - 1));

endmodule

// File: rtl/mac_mvm_sched.sv
// Row-at-a-time y = W*x sequencer: clears the MAC, streams one W row against x, hands off the result.
module mac_mvm_sched
   import mac_sched_pkg::*;
#(
   parameter int M          = 4,
   parameter int N          = 4,
   parameter int A_W        = 14,
   parameter int F_W        = 28,
   parameter int RST_CYC    = 4,
   parameter int SETTLE_CYC = 4,
   localparam int WA_W = (M * N > 1) ? $clog2(M * N) : 1,
   localparam int XA_W = (N > 1) ? $clog2(N) : 1,
   localparam int RW_W = (M > 1) ? $clog2(M) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [WA_W-1:0] w_addr,
   output logic [XA_W-1:0] x_addr,
   output logic            mem_re,
   input  logic [A_W-1:0]  w_rdata,
   input  logic [A_W-1:0]  x_rdata,
   output logic [A_W-1:0]  mac_a,
   output logic [A_W-1:0]  mac_b,
   output logic            mac_valid_in,
   output logic            mac_reset,
   input  logic            mac_valid_out,
   input  logic [F_W-1:0]  mac_f,
   output logic [F_W-1:0]  y_data,
   output logic [RW_W-1:0] y_row,
   output logic            y_valid,
   input  logic            y_ready
);

   localparam int CNT_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int VC_W    = $clog2(N + 1);

   sched_state_t    r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [VC_W-1:0]  r_vcnt;
   logic             r_busy, r_done, r_err;
   logic             r_mem_re, r_mac_valid_in, r_mac_reset;
   logic [F_W-1:0]   r_y_data;
   logic [RW_W-1:0]  r_y_row;
   logic             r_y_valid;

   logic            w_last_col, w_last_row;
   logic [RW_W-1:0] w_row;

   mac_sched_addr_gen #(.M(M), .N(N)) u_addr_gen (
      .clk        (clk),
      .rst_n      (reset),
      .i_row_clr  ((r_state == IDLE) && start),
      .i_row_inc  ((r_state == OUTPUT) && y_ready && !w_last_row),
      .i_col_clr  (r_state == SETTLE),
      .i_col_inc  ((r_state == ISSUE) && !w_last_col),
      .o_w_addr   (w_addr),
      .o_x_addr   (x_addr),
      .o_row      (w_row),
      .o_last_col (w_last_col),
      .o_last_row (w_last_row)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_vcnt         <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_mem_re       <= 1'b0;
         r_mac_valid_in <= 1'b0;
         r_mac_reset    <= 1'b1;
         r_y_data       <= '0;
         r_y_row        <= '0;
         r_y_valid      <= 1'b0;
      end else begin
         r_done         <= 1'b0;
         r_mac_valid_in <= r_mem_re;
         // A MAC result outside ISSUE/DRAIN means the MAC and sequencer disagree.
         if (mac_valid_out && (r_state inside {IDLE, CLEAR, SETTLE, OUTPUT}))
            r_err <= 1'b1;
         case (r_state)
            IDLE: begin
               r_mac_reset <= 1'b0;
               if (start) begin
                  r_state     <= CLEAR;
                  r_mac_reset <= 1'b1;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_err       <= 1'b0;
               end
            end
            CLEAR: begin
               if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                  r_state     <= SETTLE;
                  r_mac_reset <= 1'b0;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SETTLE: begin
               r_vcnt <= '0;
               if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                  r_state  <= ISSUE;
                  r_mem_re <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ISSUE: begin
               if (w_last_col) begin
                  r_state  <= DRAIN;
                  r_mem_re <= 1'b0;
               end
            end
            OUTPUT: begin
               if (y_ready) begin
                  r_y_valid <= 1'b0;
                  if (w_last_row) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state     <= CLEAR;
                     r_mac_reset <= 1'b1;
                     r_cnt       <= '0;
                  end
               end
            end
            default: ;
         endcase
         if ((r_state == ISSUE || r_state == DRAIN) && mac_valid_out) begin
            if (r_vcnt == VC_W'(N - 1)) begin
               r_y_data  <= mac_f;
               r_y_row   <= w_row;
               r_y_valid <= 1'b1;
               r_mem_re  <= 1'b0;
               r_state   <= OUTPUT;
            end else begin
               r_vcnt <= r_vcnt + 1'b1;
            end
         end
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign mem_re       = r_mem_re;
   assign mac_valid_in = r_mac_valid_in;
   assign mac_reset    = r_mac_reset;
   assign mac_a        = w_rdata;
   assign mac_b        = x_rdata;
   assign y_data       = r_y_data;
   assign y_row        = r_y_row;
   assign y_valid      = r_y_valid;

endmodule

// File: tb/tb_mac_mvm_sched.sv
// Bench for mac_mvm_sched with behavioural memories, a saturating MAC model and a result scoreboard.
module tb_mac_mvm_sched;
   import mac_sched_pkg::*;

   localparam int M = 2, N = 4, A_W = 14, F_W = 28;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, y_ready = 1'b1, stub_vo = 1'b0;
   logic busy, done, err, mem_re, mac_valid_in, mac_reset, mac_valid_out, y_valid;
   logic [2:0] w_addr;
   logic [1:0] x_addr;
   logic [0:0] y_row;
   logic signed [A_W-1:0] w_rdata, x_rdata, mac_a, mac_b;
   logic signed [F_W-1:0] mac_f, y_data;

   logic signed [A_W-1:0] wmem [0:M*N-1];
   logic signed [A_W-1:0] xmem [0:N-1];

   typedef struct { int row; longint data; } exp_t;
   exp_t exp_q[$];
   exp_t e;

   int n_checks = 0, n_err = 0, cyc = 0, t0 = 0, hs_cnt = 0, done_cnt = 0, d0, h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_mvm_sched #(.M(M), .N(N), .A_W(A_W), .F_W(F_W), .RST_CYC(4), .SETTLE_CYC(4)) dut (
      .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .w_addr(w_addr), .x_addr(x_addr), .mem_re(mem_re), .w_rdata(w_rdata), .x_rdata(x_rdata),
      .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_reset(mac_reset),
      .mac_valid_out(mac_valid_out), .mac_f(mac_f), .y_data(y_data), .y_row(y_row),
      .y_valid(y_valid), .y_ready(y_ready)
   );

   always @(posedge clk) if (mem_re) begin
      w_rdata <= wmem[w_addr];
      x_rdata <= xmem[x_addr];
   end

   // Saturating MAC model: accumulates on valid_in, result appears MAC_VALID_LAT cycles later.
   function automatic logic signed [F_W-1:0] sat_add(input logic signed [F_W-1:0] acc,
                                                      input logic signed [A_W-1:0] a, b);
      logic signed [F_W+1:0] s;
      s = acc + a * b;
      if (s > MAC_SAT_MAX) return MAC_SAT_MAX;
      if (s < MAC_SAT_MIN) return MAC_SAT_MIN;
      return s[F_W-1:0];
   endfunction

   logic signed [F_W-1:0] acc;
   logic [MAC_VALID_LAT-1:0] pv;
   logic signed [F_W-1:0] pf [MAC_VALID_LAT];
   always @(posedge clk) begin
      if (mac_reset) begin
         acc <= '0;
         pv  <= '0;
         for (int k = 0; k < MAC_VALID_LAT; k++) pf[k] <= '0;
      end else begin
         if (mac_valid_in) acc <= sat_add(acc, mac_a, mac_b);
         pv    <= {pv[MAC_VALID_LAT-2:0], mac_valid_in};
         pf[0] <= mac_valid_in ? sat_add(acc, mac_a, mac_b) : acc;
         for (int k = 1; k < MAC_VALID_LAT; k++) pf[k] <= pf[k-1];
      end
   end
   assign mac_f         = pf[MAC_VALID_LAT-1];
   assign mac_valid_out = pv[MAC_VALID_LAT-1] | stub_vo;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every handshake is compared against the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && y_valid && y_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_result: got row %0d y=%0d expected none", y_row, y_data);
         end else begin
            e = exp_q.pop_front();
            $display("result row %0d y=%0d (expected row %0d y=%0d)", y_row, y_data, e.row, e.data);
            chk("y_data", y_data, e.data);
            chk("y_row", y_row, e.row);
         end
      end
      if (done) done_cnt++;
   end

   task automatic push(input int row, input longint data);
      exp_t x;
      x.row = row;
      x.data = data;
      exp_q.push_back(x);
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL %s_timeout: busy got 1 expected 0", name);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_yvalid(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (y_valid) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL %s_timeout: y_valid got 0 expected 1", name);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_mem_re"}, mem_re, 0);
      chk({tag, "_mac_valid_in"}, mac_valid_in, 0);
      chk({tag, "_mac_reset"}, mac_reset, 1);
      chk({tag, "_y_valid"}, y_valid, 0);
      chk({tag, "_y_data"}, y_data, 0);
      chk({tag, "_y_row"}, y_row, 0);
      chk({tag, "_w_addr"}, w_addr, 0);
      chk({tag, "_x_addr"}, x_addr, 0);
   endtask

   task automatic load_w1();
      for (int c = 0; c < N; c++) begin
         wmem[c]     = A_W'(c + 1);
         wmem[N + c] = -14'sd1;
         xmem[c]     = A_W'(5 + c);
      end
   endtask

   initial begin
      bit ok;
      load_w1();
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("mac_reset_release", mac_reset, 0);

      // Basic run with latency and done-pulse checks.
      push(0, 70); push(1, -26);
      d0 = done_cnt; h0 = hs_cnt;
      do_start();
      wait_yvalid("latency", ok);
      if (ok) chk("y_valid_latency", cyc - t0, 19);
      wait_idle("run1");
      chk("run1_done_pulses", done_cnt - d0, 1);
      chk("run1_results", hs_cnt - h0, 2);

      // Positive and negative saturation.
      for (int i = 0; i < M * N; i++) wmem[i] = 14'sd8191;
      for (int c = 0; c < N; c++) xmem[c] = 14'sd8191;
      push(0, 134217727); push(1, 134217727);
      do_start();
      wait_idle("sat_pos");
      for (int c = 0; c < N; c++) xmem[c] = -14'sd8192;
      push(0, -134217728); push(1, -134217728);
      do_start();
      wait_idle("sat_neg");

      // Output stall: result held, no new row activity until the handshake.
      for (int i = 0; i < M * N; i++) wmem[i] = '0;
      wmem[0] = 14'sd2; wmem[N + 3] = 14'sd3;
      for (int c = 0; c < N; c++) xmem[c] = A_W'(5 + c);
      push(0, 10); push(1, 24);
      y_ready = 1'b0;
      do_start();
      wait_yvalid("stall", ok);
      for (int i = 0; i < 10; i++) begin
         chk("stall_y_valid", y_valid, 1);
         chk("stall_y_data", y_data, 10);
         chk("stall_y_row", y_row, 0);
         chk("stall_no_activity", {mem_re, mac_reset}, 0);
         @(negedge clk);
      end
      @(posedge clk); #1 y_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("stall_next_row_clear", mac_reset, 1);
      chk("stall_y_valid_fall", y_valid, 0);
      wait_idle("stall");

      // start pulses while busy are ignored; start on the done cycle begins a new run.
      load_w1();
      push(0, 70); push(1, -26);
      h0 = hs_cnt;
      do_start();
      repeat (6) @(posedge clk);
      #1 start = 1'b1; @(posedge clk); #1 start = 1'b0;
      repeat (15) @(posedge clk);
      #1 start = 1'b1; @(posedge clk); #1 start = 1'b0;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL busy_start_timeout: done got 0 expected 1");
      end
      chk("busy_start_results", hs_cnt - h0, 2);
      push(0, 70); push(1, -26);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("restart_after_done_busy", busy, 1);
      wait_idle("restart");

      // Reset in the middle of row 1, then a clean rerun.
      push(0, 70); push(1, -26);
      do_start();
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_re && w_addr >= 3'd4) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL row1_issue_timeout: mem_re on row 1 got 0 expected 1");
      end
      @(posedge clk); #1 rst_n = 1'b0;
      #1 check_reset_vals("midrun_reset");
      chk("midrun_pending_rows", exp_q.size(), 1);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      push(0, 70); push(1, -26);
      do_start();
      wait_idle("after_reset");
      chk("after_reset_err", err, 0);

      // Stray MAC valid in IDLE raises a sticky err cleared by the next start.
      @(posedge clk); #1 stub_vo = 1'b1;
      @(posedge clk); #1 stub_vo = 1'b0;
      @(negedge clk);
      chk("err_set", err, 1);
      repeat (4) @(negedge clk);
      chk("err_sticky", err, 1);
      push(0, 70); push(1, -26);
      do_start();
      @(negedge clk);
      chk("err_cleared_by_start", err, 0);
      wait_idle("err_run");

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mac_mvm_sched.md
Name: mac_mvm_sched

Overview:
- Sequencer for the 3-stage pipelined saturating MAC; computes y = W·x one row at a time.
- Reads a W row and the x vector from two synchronous-read memories and streams operand pairs into the MAC.
- Clears the MAC between rows, counts MAC valid_out pulses, and emits one saturated row result per row over a valid/ready handshake.
- Sits between the layer memories and the MAC instance in the neural-network datapath.

Parameters:
- M, 4: number of rows (outputs).
- N, 4: number of columns (products accumulated per row).
- A_W, 14: signed operand width.
- F_W, 28: signed accumulator/result width.
- RST_CYC, 4: cycles mac_reset is held high per row clear.
- SETTLE_CYC, 4: idle cycles after mac_reset deasserts before the first issue, covering the MAC's internal reset delay line.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full M-row run.
- busy  out  1  high from start acceptance until the last row is handed off.
- done  out  1  one-cycle pulse after the last row's handshake.
- err  out  1  sticky protocol error.
- w_addr  out  clog2(M*N)  W memory address, equal to row*N+col.
- x_addr  out  clog2(N)  x memory address, equal to col.
- mem_re  out  1  read enable for both memories; read data returns 1 cycle later.
- w_rdata  in  A_W  signed W data.
- x_rdata  in  A_W  signed x data.
- mac_a  out  A_W  MAC operand a, driven from w_rdata.
- mac_b  out  A_W  MAC operand b, driven from x_rdata.
- mac_valid_in  out  1  MAC valid_in.
- mac_reset  out  1  MAC synchronous active-high clear.
- mac_valid_out  in  1  MAC valid_out.
- mac_f  in  F_W  MAC accumulator value.
- y_data  out  F_W  row result.
- y_row  out  clog2(M)  row index of y_data.
- y_valid  out  1  result valid.
- y_ready  in  1  consumer ready.

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_re=0, mac_valid_in=0, mac_reset=1, y_valid=0, y_data=0, y_row=0, addresses=0. The FSM resets to IDLE. mac_reset drops to 0 on the first clock edge after reset is released.
- FSM states: IDLE, CLEAR, SETTLE, ISSUE, DRAIN, OUTPUT.
- IDLE: if start=1, set row=0 and go to CLEAR. start is ignored in every other state.
- CLEAR: mac_reset=1 for exactly RST_CYC cycles, then go to SETTLE.
- SETTLE: mac_reset=0 for SETTLE_CYC cycles. Clear col and vcnt, then go to ISSUE.
- ISSUE: mem_re=1 for exactly N consecutive cycles, col = 0..N-1, then go to DRAIN.
  - mac_valid_in is mem_re delayed 1 cycle, aligned with rdata. mac_a = w_rdata, mac_b = x_rdata.
  - mac_a/mac_b are combinational pass-through; they are don't-care when mac_valid_in=0.
- DRAIN (also counting during ISSUE): vcnt increments on each cycle with mac_valid_out=1.
  - On the cycle where mac_valid_out=1 and vcnt==N-1: register y_data <= mac_f and y_row <= row, then go to OUTPUT.
  - No timeout. The MAC's fixed 5-cycle valid latency guarantees completion.
- OUTPUT: y_valid=1; y_data and y_row are held stable while y_ready=0.
  - On y_valid & y_ready: if row==M-1, go to IDLE, pulse done, drop busy. Otherwise row++ and go to CLEAR.
  - y_valid falls on the cycle after the handshake.
- Saturation is performed inside the MAC. The block passes mac_f through unchanged with no width change.
- err is set when mac_valid_out=1 in IDLE, CLEAR, SETTLE or OUTPUT. It stays set until the next accepted start.
- Latency with defaults: the start edge is t0, CLEAR runs t1–t4, SETTLE t5–t8, ISSUE t9–t12, mac_valid_in t10–t13, mac_valid_out t15–t18, y_valid rises at t19. Each further row adds RST_CYC+SETTLE_CYC+N+7 cycles, plus any y_ready stall.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values, including mac_reset=1. Any partial row is discarded.
- start and y_ready arriving in the same cycle as the final handshake: start is ignored, since the FSM is not in IDLE that cycle.

Decomposition:
- Package mac_sched_pkg holds:
  - the state enum type;
  - localparams for the MAC valid latency (5) and the MAC saturation limits (2^(F_W-1)-1 and -2^(F_W-1)), used by the bench.
- One sub-module, mac_sched_addr_gen: holds the row/col counters and generates w_addr, x_addr and the last-col/last-row flags.
- FSM, vcnt and the output register stay in the top level.

Test Plan:
- M=2, N=4, W={{1,2,3,4},{-1,-1,-1,-1}}, x={5,6,7,8}, y_ready=1 -> y=70 (row 0) then y=-26 (row 1); done pulses once; y_valid first rises at t19.
- Row 0 all 8191, x all 8191 -> y_data=134217727 (positive saturation); a row of 8191 with x all -8192 -> y_data=-134217728.
- Hold y_ready=0 for 10 cycles while in OUTPUT -> y_data, y_row and y_valid stay stable; no CLEAR and no mem_re; on release, the handshake completes and row 1 begins.
- Pulse start while busy -> run unaffected and exactly M results; start on the IDLE cycle after done -> new run begins.
- Drive reset low during ISSUE of row 1 -> all outputs at reset values immediately; a new start yields a correct row 0 with no stale accumulation.
- Stub MAC asserts mac_valid_out in IDLE -> err=1, held until the next start.
